// File: rtl/pfd_cal_sequencer_if.sv
// Handshake and write-port bundle between the PFD calibration sequencer and its controller/offset RAM.
// The master side requests runs and supplies offsets; the slave side is the sequencer itself.
interface pfd_cal_sequencer_if #(
  parameter int N_SLICES = 16,
  parameter int OFS_W    = 8,
  parameter int WAIT_W   = 16
);
  localparam int IDX_W = $clog2(N_SLICES);
  localparam int SUM_W = OFS_W + IDX_W;

  logic                start;
  logic                abort;
  logic [WAIT_W-1:0]   wait_cycles;
  logic [OFS_W-1:0]    pfd_offset_in;
  logic [N_SLICES-1:0] en_pfd_cal;
  logic [IDX_W-1:0]    slice_sel;
  logic                wr_en;
  logic [IDX_W-1:0]    wr_addr;
  logic [OFS_W-1:0]    wr_data;
  logic [SUM_W-1:0]    offset_sum;
  logic                busy;
  logic                done;
  logic                aborted;

  modport master (
    output start, abort, wait_cycles, pfd_offset_in,
    input  en_pfd_cal, slice_sel, wr_en, wr_addr, wr_data, offset_sum, busy, done, aborted
  );

  modport slave (
    input  start, abort, wait_cycles, pfd_offset_in,
    output en_pfd_cal, slice_sel, wr_en, wr_addr, wr_data, offset_sum, busy, done, aborted
  );
endinterface

// File: rtl/pfd_cal_sequencer.sv
// Walks every ADC slice through enable / settle / capture, writes each captured PFD offset
// to the offset store and keeps a non-wrapping signed running sum of all captures.
module pfd_cal_sequencer #(
  parameter int N_SLICES = 16,
  parameter int OFS_W    = 8,
  parameter int WAIT_W   = 16
) (
  input logic                 clk,
  input logic                 rst,
  pfd_cal_sequencer_if.slave  bus
);
  localparam int IDX_W = $clog2(N_SLICES);
  localparam int SUM_W = OFS_W + IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENABLE,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    slice_idx_q;
  logic [WAIT_W-1:0]   cnt_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [SUM_W-1:0]    sum_q;
  logic                en_act_q;
  logic                cap_q;
  logic                busy_q;
  logic                done_q;
  logic                aborted_q;

  logic [WAIT_W-1:0]   wait_d;
  logic [SUM_W-1:0]    sum_d;
  logic                last_slice;

  // A zero settle request still needs one settle cycle so the counter exit condition is reachable.
  assign wait_d     = (bus.wait_cycles == '0) ? WAIT_W'(1) : bus.wait_cycles;
  assign sum_d      = sum_q + {{IDX_W{bus.pfd_offset_in[OFS_W-1]}}, bus.pfd_offset_in};
  assign last_slice = (slice_idx_q == IDX_W'(N_SLICES - 1));

  // NOTE: every register here uses non-blocking assignment so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      slice_idx_q <= '0;
      cnt_q       <= '0;
      wait_q      <= WAIT_W'(1);
      sum_q       <= '0;
      en_act_q    <= 1'b0;
      cap_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (state_q != S_IDLE && bus.abort) begin
        state_q   <= S_IDLE;
        en_act_q  <= 1'b0;
        cap_q     <= 1'b0;
        busy_q    <= 1'b0;
        aborted_q <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              slice_idx_q <= '0;
              sum_q       <= '0;
              wait_q      <= wait_d;
              en_act_q    <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= S_ENABLE;
            end
          end
          S_ENABLE: begin
            cnt_q   <= wait_q;
            state_q <= S_SETTLE;
          end
          S_SETTLE: begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q <= WAIT_W'(1)) begin
              cap_q   <= 1'b1;
              state_q <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            sum_q <= sum_d;
            cap_q <= 1'b0;
            if (last_slice) begin
              en_act_q <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              slice_idx_q <= slice_idx_q + 1'b1;
              state_q     <= S_ENABLE;
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // The write strobe is gated by abort in the same cycle so an abort during CAPTURE suppresses the write.
  assign bus.wr_en      = cap_q & ~bus.abort;
  assign bus.wr_addr    = cap_q ? slice_idx_q : '0;
  assign bus.wr_data    = cap_q ? bus.pfd_offset_in : '0;
  assign bus.en_pfd_cal = en_act_q ? ({{(N_SLICES-1){1'b0}}, 1'b1} << slice_idx_q) : '0;
  assign bus.slice_sel  = slice_idx_q;
  assign bus.offset_sum = sum_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;
endmodule

// File: tb/tb_pfd_cal_sequencer.sv
// Directed bench for pfd_cal_sequencer: cycle-exact write timing, sums, abort and reset behaviour.
module tb_pfd_cal_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pfd_cal_sequencer_if #(.N_SLICES(16), .OFS_W(8), .WAIT_W(16)) bus ();

  pfd_cal_sequencer #(.N_SLICES(16), .OFS_W(8), .WAIT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  int          wr_cyc_q[$];
  int          wr_addr_q[$];
  int          wr_data_q[$];
  logic [15:0] wr_en_q[$];
  int          done_cyc, done_cnt, ab_cyc, ab_cnt;
  logic        ab_busy;
  logic [15:0] ab_en;
  int          ab_sum;

  // Caller must be at a negedge. Cycle n is the interval after the n-th edge following the start edge.
  task automatic run_seq(input int wc, input bit neg_mode, input int abort_at,
                         input bit disturb, input int max_cyc);
    wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); wr_en_q.delete();
    done_cyc = -1; done_cnt = 0; ab_cyc = -1; ab_cnt = 0;
    bus.wait_cycles = 16'(wc);
    bus.start = 1'b1;
    bus.abort = (abort_at == 0);
    @(posedge clk);
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk);
      bus.start = disturb && (n % 5 == 2);
      if (disturb) bus.wait_cycles = 16'(n * 37);
      bus.abort = (n == abort_at);
      bus.pfd_offset_in = neg_mode ? 8'h80 : 8'(bus.slice_sel);
      #1;
      if (bus.wr_en) begin
        wr_cyc_q.push_back(n);
        wr_addr_q.push_back(int'(bus.wr_addr));
        wr_data_q.push_back(int'($signed(bus.wr_data)));
        wr_en_q.push_back(bus.en_pfd_cal);
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (bus.aborted) begin
        ab_cnt++;
        if (ab_cyc < 0) begin
          ab_cyc  = n;
          ab_busy = bus.busy;
          ab_en   = bus.en_pfd_cal;
          ab_sum  = int'($signed(bus.offset_sum));
        end
      end
      if (done_cyc >= 0 || ab_cyc >= 0) break;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.wait_cycles = '0; bus.pfd_offset_in = '0;
    #1;
    n_cmp++;
    if ({bus.en_pfd_cal, bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.done, bus.aborted} !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs: en=%h wr_en=%b addr=%0d data=%h busy=%b done=%b aborted=%b, required all 0",
               bus.en_pfd_cal, bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.done, bus.aborted);
    end
    n_cmp++;
    if (bus.slice_sel !== 4'd0 || bus.offset_sum !== 12'd0) begin
      n_mis++;
      $display("FAIL reset_state: slice_sel=%0d offset_sum=%0d, required 0 0", bus.slice_sel, bus.offset_sum);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_full_run(input string tag, input int period, input int exp_done,
                                input int exp_sum, input bit neg_mode);
    logic [15:0] one16;
    logic [15:0] exp_en;
    int          exp_data;
    one16 = 16'h1;
    n_cmp++;
    if (wr_cyc_q.size() !== 16) begin
      n_mis++;
      $display("FAIL %s_write_count: got %0d, required 16", tag, wr_cyc_q.size());
    end
    for (int k = 0; k < 16 && k < wr_cyc_q.size(); k++) begin
      exp_en   = one16 << k;
      exp_data = neg_mode ? -128 : k;
      n_cmp++;
      if (wr_cyc_q[k] !== period * k + period || wr_addr_q[k] !== k ||
          wr_data_q[k] !== exp_data || wr_en_q[k] !== exp_en) begin
        n_mis++;
        $display("FAIL %s_write%0d: cyc=%0d addr=%0d data=%0d en=%h, required cyc=%0d addr=%0d data=%0d en=%h",
                 tag, k, wr_cyc_q[k], wr_addr_q[k], wr_data_q[k], wr_en_q[k],
                 period * k + period, k, exp_data, exp_en);
      end
    end
    n_cmp++;
    if (done_cyc !== exp_done || done_cnt !== 1 || ab_cnt !== 0) begin
      n_mis++;
      $display("FAIL %s_done: cyc=%0d pulses=%0d aborted=%0d, required cyc=%0d pulses=1 aborted=0",
               tag, done_cyc, done_cnt, ab_cnt, exp_done);
    end
    n_cmp++;
    if ($signed(bus.offset_sum) !== 12'(exp_sum) || bus.busy !== 1'b1) begin
      n_mis++;
      $display("FAIL %s_sum_at_done: sum=%0d busy=%b, required sum=%0d busy=1",
               tag, $signed(bus.offset_sum), bus.busy, exp_sum);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ($signed(bus.offset_sum) !== 12'(exp_sum) || bus.busy !== 1'b0 || bus.en_pfd_cal !== 16'h0) begin
      n_mis++;
      $display("FAIL %s_hold: sum=%0d busy=%b en=%h, required sum=%0d busy=0 en=0",
               tag, $signed(bus.offset_sum), bus.busy, bus.en_pfd_cal, exp_sum);
    end
  endtask

  task automatic test_basic();
    run_seq(4, 1'b0, -1, 1'b0, 200);
    check_full_run("basic", 6, 97, 120, 1'b0);
  endtask

  task automatic test_wait_zero();
    run_seq(0, 1'b0, -1, 1'b0, 200);
    check_full_run("wait0", 3, 49, 120, 1'b0);
  endtask

  task automatic test_negative_sum();
    run_seq(2, 1'b1, -1, 1'b0, 200);
    check_full_run("neg", 4, 65, -2048, 1'b1);
  endtask

  task automatic test_mid_run_disturb();
    run_seq(4, 1'b0, -1, 1'b1, 200);
    check_full_run("disturb", 6, 97, 120, 1'b0);
  endtask

  task automatic test_abort_idle();
    run_seq(2, 1'b0, 0, 1'b0, 200);
    check_full_run("abort_idle", 4, 65, 120, 1'b0);
  endtask

  task automatic test_abort_capture();
    // Slice 5 captures in cycle 36 with wait=4.
    run_seq(4, 1'b0, 36, 1'b0, 200);
    n_cmp++;
    if (wr_cyc_q.size() !== 5 || (wr_addr_q.size() > 0 && wr_addr_q[wr_addr_q.size()-1] !== 4)) begin
      n_mis++;
      $display("FAIL abort_writes: count=%0d, required 5 writes ending at slice 4", wr_cyc_q.size());
    end
    n_cmp++;
    if (ab_cyc !== 37 || ab_busy !== 1'b0 || ab_en !== 16'h0 || done_cnt !== 0) begin
      n_mis++;
      $display("FAIL abort_pulse: cyc=%0d busy=%b en=%h done=%0d, required cyc=37 busy=0 en=0 done=0",
               ab_cyc, ab_busy, ab_en, done_cnt);
    end
    n_cmp++;
    if (ab_sum !== 10) begin
      n_mis++;
      $display("FAIL abort_sum: got %0d, required 10", ab_sum);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ($signed(bus.offset_sum) !== 12'sd10 || bus.aborted !== 1'b0 || bus.busy !== 1'b0) begin
      n_mis++;
      $display("FAIL abort_hold: sum=%0d aborted=%b busy=%b, required 10 0 0",
               $signed(bus.offset_sum), bus.aborted, bus.busy);
    end
  endtask

  task automatic test_reset_midrun();
    bus.wait_cycles = 16'd4;
    bus.start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 21; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.pfd_offset_in = 8'(bus.slice_sel);
    end
    #1;
    n_cmp++;
    if (bus.en_pfd_cal !== 16'h0008 || bus.busy !== 1'b1 || $signed(bus.offset_sum) !== 12'sd3) begin
      n_mis++;
      $display("FAIL pre_reset: en=%h busy=%b sum=%0d, required en=0008 busy=1 sum=3",
               bus.en_pfd_cal, bus.busy, $signed(bus.offset_sum));
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.en_pfd_cal, bus.wr_en, bus.slice_sel, bus.offset_sum, bus.busy, bus.done, bus.aborted} !== '0) begin
      n_mis++;
      $display("FAIL midrun_reset: en=%h wr_en=%b sel=%0d sum=%0d busy=%b done=%b aborted=%b, required all 0",
               bus.en_pfd_cal, bus.wr_en, bus.slice_sel, bus.offset_sum, bus.busy, bus.done, bus.aborted);
    end
    @(negedge clk);
    rst = 1'b0;
    run_seq(1, 1'b0, -1, 1'b0, 200);
    check_full_run("post_reset", 3, 49, 120, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_zero();
    test_negative_sum();
    test_mid_run_disturb();
    test_abort_idle();
    test_abort_capture();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/pfd_cal_sequencer.md
PFD_CAL_SEQUENCER -- requirements
Module: pfd_cal_sequencer

Interface
REQ-001 SHALL provide parameter N_SLICES, default 16, number of ADC slices calibrated per run (power of 2, 2..32).
REQ-002 SHALL provide parameter OFS_W, default 8, width of the signed PFD offset word.
REQ-003 SHALL provide parameter WAIT_W, default 16, width of the settle-time count.
REQ-004 SHALL have port clk, input, 1, single clock for all state.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, level-sampled run request, honoured only in IDLE.
REQ-007 SHALL have port abort, input, 1, terminate the run in progress.
REQ-008 SHALL have port wait_cycles, input, WAIT_W, settle cycles per slice (0 treated as 1).
REQ-009 SHALL have port pfd_offset_in, input, OFS_W, signed offset estimate from the averaging datapath for the selected slice.
REQ-010 SHALL have port en_pfd_cal, output, N_SLICES, one-hot calibration enable per slice.
REQ-011 SHALL have port slice_sel, output, $clog2(N_SLICES), index of the slice under calibration.
REQ-012 SHALL have ports wr_en (1), wr_addr ($clog2(N_SLICES)) and wr_data (OFS_W), outputs, one-cycle write of the captured offset.
REQ-013 SHALL have port offset_sum, output, OFS_W+$clog2(N_SLICES), signed running sum of the captured offsets.
REQ-014 SHALL have ports busy, done and aborted, outputs, 1 each: run active, one-cycle completion pulse, and one-cycle abort pulse.

Function
REQ-015 SHALL implement the states IDLE, ENABLE, SETTLE, CAPTURE and DONE.
REQ-016 SHALL, in IDLE with start=1, clear slice_idx and offset_sum, latch wait_q=max(wait_cycles,1), and enter ENABLE.
REQ-017 SHALL, in ENABLE, load the settle counter with wait_q and enter SETTLE after one cycle.
REQ-018 SHALL, in SETTLE, decrement the counter each cycle and enter CAPTURE on the cycle the counter equals 1, so SETTLE lasts exactly wait_q cycles.
REQ-019 SHALL, in CAPTURE, assert wr_en for one cycle with wr_addr=slice_idx and wr_data=pfd_offset_in, and add sign-extended pfd_offset_in to offset_sum.
REQ-020 SHALL, from CAPTURE, increment slice_idx and enter ENABLE if slice_idx<N_SLICES-1, else enter DONE.
REQ-021 SHALL, in DONE, pulse done for one cycle and return to IDLE.
REQ-022 SHALL drive en_pfd_cal[slice_idx]=1 in ENABLE, SETTLE and CAPTURE, and all zeros otherwise.
REQ-023 SHALL drive slice_sel=slice_idx at all times and busy=1 in every state except IDLE.
REQ-024 SHALL use per-slice latency wait_q+2 cycles; with start sampled at edge 0, done SHALL be high in cycle N_SLICES*(wait_q+2)+1.
REQ-025 SHALL ignore changes to wait_cycles after start is latched, and SHALL ignore start while busy=1.
REQ-026 SHALL, when abort=1 in any non-IDLE state, go to IDLE on the next edge and pulse aborted with no write and no done pulse; abort wins over a simultaneous CAPTURE write.
REQ-027 SHALL have no effect when abort=1 in IDLE, and SHALL honour a simultaneous start in that case.
REQ-028 SHALL never wrap offset_sum; its width covers the worst case N_SLICES*(-2^(OFS_W-1)).
REQ-029 SHALL hold offset_sum after DONE or abort until the next accepted start.

Reset
REQ-030 SHALL, while rst=1, asynchronously force state IDLE, slice_idx=0, counter=0, wait_q=1, offset_sum=0, and en_pfd_cal, wr_en, wr_addr, wr_data, busy, done and aborted all 0.
REQ-031 SHALL discard a run in progress when reset asserts mid-run, with no done or aborted pulse, and SHALL accept start on the first edge after rst deasserts.

Verification
REQ-032 Bench SHALL cover: N_SLICES=16, wait_cycles=4, pfd_offset_in=slice index -> 16 writes (addr k, data k) at cycles 6k+6, done in cycle 97, offset_sum=120.
REQ-033 Bench SHALL cover: wait_cycles=0 -> behaves as 1, per-slice period 3 cycles, done in cycle 49.
REQ-034 Bench SHALL cover: pfd_offset_in=-128 for all slices -> offset_sum=-2048 with no overflow.
REQ-035 Bench SHALL cover: abort asserted in the CAPTURE cycle of slice 5 -> no write for slice 5, aborted pulses, busy=0 next cycle, en_pfd_cal=0.
REQ-036 Bench SHALL cover: start re-pulsed mid-run and wait_cycles changed mid-run -> no effect on sequence timing.
REQ-037 Bench SHALL cover: rst asserted during SETTLE of slice 3 -> all outputs 0 immediately, next start begins at slice 0.
